// File: rtl/window_stream_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : window_stream_arbiter
// Brief    : Packet-atomic round-robin merge of the per-level serialized
//            window streams into one tagged output stream. A level is granted
//            for exactly PKT_BEATS beats. Each output beat carries its source
//            level and a last-beat flag.
// Revision : 1.0 - initial release
// ============================================================================
module window_stream_arbiter #(
    parameter int BUS_WIDTH = 128,
    parameter int LEVELS    = 7,
    parameter int PKT_BEATS = 10,
    parameter int SRC_W     = 3,
    parameter int CNT_W     = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [LEVELS-1:0]           in_valid,
    input  logic [BUS_WIDTH*LEVELS-1:0] in_stream,
    output logic [LEVELS-1:0]           in_ready,
    output logic                        out_valid,
    output logic [BUS_WIDTH-1:0]        out_stream,
    output logic                        out_last,
    output logic [SRC_W-1:0]            out_src,
    input  logic                        out_ready,
    output logic [CNT_W-1:0]            pkt_count
);

    localparam int               c_beat_w    = (PKT_BEATS > 1) ? $clog2(PKT_BEATS) : 1;
    localparam logic [c_beat_w-1:0] c_last_beat = c_beat_w'(PKT_BEATS - 1);
    // Pointer starts at the highest level so the first search begins at level 0.
    localparam logic [SRC_W-1:0] c_ptr_rst   = SRC_W'(LEVELS - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [SRC_W-1:0]       r_grant;
    logic [SRC_W-1:0]       r_ptr;
    logic [c_beat_w-1:0]    r_beat_cnt;
    logic                   r_out_valid;
    logic [BUS_WIDTH-1:0]   r_out_stream;
    logic                   r_out_last;
    logic [SRC_W-1:0]       r_out_src;
    logic [CNT_W-1:0]       r_pkt_count;

    logic                   w_req_found;
    logic [SRC_W-1:0]       w_req_sel;
    logic                   w_gnt_valid;
    logic [BUS_WIDTH-1:0]   w_gnt_data;
    logic                   w_can_load;
    logic                   w_accept;
    logic                   w_pkt_done;

    // The single output register may load when empty or being drained this cycle.
    assign w_can_load = !r_out_valid || out_ready;
    assign w_accept   = (r_state == ST_BURST) && w_gnt_valid && w_can_load;
    assign w_pkt_done = w_accept && (r_beat_cnt == c_last_beat);

    // Round-robin search: first requester above the pointer, else first from level 0.
    always_comb begin
        w_req_found = 1'b0;
        w_req_sel   = '0;
        for (int j = 0; j < LEVELS; j++) begin
            if (!w_req_found && in_valid[j] && (SRC_W'(j) > r_ptr)) begin
                w_req_found = 1'b1;
                w_req_sel   = SRC_W'(j);
            end
        end
        for (int j = 0; j < LEVELS; j++) begin
            if (!w_req_found && in_valid[j]) begin
                w_req_found = 1'b1;
                w_req_sel   = SRC_W'(j);
            end
        end
    end

    // Select the valid and data of the currently granted level.
    always_comb begin
        w_gnt_valid = 1'b0;
        w_gnt_data  = '0;
        for (int j = 0; j < LEVELS; j++) begin
            if (r_grant == SRC_W'(j)) begin
                w_gnt_valid = in_valid[j];
                w_gnt_data  = in_stream[j*BUS_WIDTH +: BUS_WIDTH];
            end
        end
    end

    // Only the granted level sees ready, and only while locked in a burst.
    always_comb begin
        in_ready = '0;
        if (r_state == ST_BURST) begin
            for (int j = 0; j < LEVELS; j++) begin
                in_ready[j] = w_can_load && (r_grant == SRC_W'(j));
            end
        end
    end

    // Next-state logic: arbitrate in IDLE, stay locked until the packet's last beat.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_req_found) w_state_next = ST_BURST;
            ST_BURST: if (w_pkt_done)  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Grant, round-robin pointer and beat counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant    <= '0;
            r_ptr      <= c_ptr_rst;
            r_beat_cnt <= '0;
        end else begin
            if ((r_state == ST_IDLE) && w_req_found) begin
                r_grant <= w_req_sel;
            end
            if (w_pkt_done) begin
                r_beat_cnt <= '0;
                r_ptr      <= r_grant;
            end else if (w_accept) begin
                r_beat_cnt <= r_beat_cnt + c_beat_w'(1);
            end
        end
    end

    // Output stage: load on accept, drop valid once drained with nothing new.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_stream <= '0;
            r_out_last   <= 1'b0;
            r_out_src    <= '0;
        end else if (w_accept) begin
            r_out_valid  <= 1'b1;
            r_out_stream <= w_gnt_data;
            r_out_last   <= (r_beat_cnt == c_last_beat);
            r_out_src    <= r_grant;
        end else if (out_ready) begin
            r_out_valid  <= 1'b0;
        end
    end

    // Count packets as their last beat leaves on the output handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pkt_count <= '0;
        end else if (r_out_valid && out_ready && r_out_last) begin
            r_pkt_count <= r_pkt_count + CNT_W'(1);
        end
    end

    assign out_valid  = r_out_valid;
    assign out_stream = r_out_stream;
    assign out_last   = r_out_last;
    assign out_src    = r_out_src;
    assign pkt_count  = r_pkt_count;

endmodule
`default_nettype wire

// File: tb/tb_window_stream_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_window_stream_arbiter
// Brief    : Directed self-checking bench for window_stream_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_window_stream_arbiter;

    localparam int BW = 128;
    localparam int LV = 7;
    localparam int PB = 10;
    localparam int SW = 3;
    localparam int CW = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [LV-1:0]    in_valid;
    logic [BW*LV-1:0] in_stream;
    logic [LV-1:0]    in_ready;
    logic             out_valid;
    logic [BW-1:0]    out_stream;
    logic             out_last;
    logic [SW-1:0]    out_src;
    logic             out_ready;
    logic [CW-1:0]    pkt_count;

    int            checks = 0;
    int            errors = 0;
    int            sent [LV];
    logic [LV-1:0] en;
    int            cyc;
    int            stall;
    int            bub;
    bit            found;
    logic [BW-1:0] q_data [$];
    int            q_src  [$];
    bit            q_last [$];
    int            q_cyc  [$];

    window_stream_arbiter #(
        .BUS_WIDTH (BW),
        .LEVELS    (LV),
        .PKT_BEATS (PB),
        .SRC_W     (SW),
        .CNT_W     (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_stream  (in_stream),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_stream (out_stream),
        .out_last   (out_last),
        .out_src    (out_src),
        .out_ready  (out_ready),
        .pkt_count  (pkt_count)
    );

    always #5 clk = ~clk;

    // Beat signature: marker byte, level index and beat index.
    function automatic logic [BW-1:0] mk(input int j, input int k);
        logic [BW-1:0] v;
        v          = '0;
        v[127:120] = 8'hA5;
        v[71:64]   = 8'(j);
        v[15:0]    = 16'(k);
        return v;
    endfunction

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // Drive each enabled level with its next unsent beat, then let logic settle.
    task automatic apply();
        in_valid = en;
        for (int j = 0; j < LV; j++) in_stream[j*BW +: BW] = mk(j, sent[j]);
        #1;
    endtask

    // Book-keep the handshakes that will complete on the coming edge.
    task automatic commit();
        for (int j = 0; j < LV; j++) if (in_valid[j] && in_ready[j]) sent[j]++;
        if (out_valid && out_ready) begin
            q_data.push_back(out_stream);
            q_src.push_back(int'(out_src));
            q_last.push_back(out_last);
            q_cyc.push_back(cyc);
        end
        cyc++;
    endtask

    task automatic clear_q();
        q_data.delete(); q_src.delete(); q_last.delete(); q_cyc.delete();
        cyc = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en = '0;
        for (int j = 0; j < LV; j++) sent[j] = 0;
        out_ready = 1'b1;
        apply();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_q();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_out_valid"},  BW'(out_valid),  '0);
        chk({tag, "_out_stream"}, out_stream,      '0);
        chk({tag, "_out_last"},   BW'(out_last),   '0);
        chk({tag, "_out_src"},    BW'(out_src),    '0);
        chk({tag, "_in_ready"},   BW'(in_ready),   '0);
        chk({tag, "_pkt_count"},  BW'(pkt_count),  '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; out_ready = 1'b0; en = '0; in_valid = '0; in_stream = '0;
        for (int j = 0; j < LV; j++) sent[j] = 0;
        clear_q();

        // ---- Reset held with random inputs ----
        for (int c = 0; c < 5; c++) begin
            next();
            in_valid  = LV'($urandom);
            out_ready = 1'($urandom);
            for (int w = 0; w < BW*LV/32; w++) in_stream[w*32 +: 32] = $urandom;
            #1;
            chk_all_zero("rst");
        end
        en = '0; out_ready = 1'b1;
        apply();
        next();
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            next();
            apply();
            chk("idle_out_valid", BW'(out_valid), '0);
            chk("idle_in_ready",  BW'(in_ready),  '0);
        end

        // ---- Single level 3 packet ----
        clear_q();
        for (int c = 0; c < 13; c++) begin
            next();
            en = '0;
            en[3] = (sent[3] < PB);
            apply();
            chk("l3_in_ready", BW'(in_ready), (c >= 1 && c <= 10) ? BW'(7'b0001000) : '0);
            chk("l3_out_valid", BW'(out_valid), (c >= 2 && c <= 11) ? BW'(1) : '0);
            if (c >= 2 && c <= 11) begin
                chk("l3_out_src",    BW'(out_src),  BW'(3));
                chk("l3_out_stream", out_stream,    mk(3, c - 2));
                chk("l3_out_last",   BW'(out_last), (c == 11) ? BW'(1) : '0);
            end
            if (c == 12) chk("l3_pkt_count", BW'(pkt_count), BW'(1));
            commit();
        end

        // ---- All levels continuously valid ----
        do_reset();
        for (int c = 0; c < 200 && q_src.size() < 80; c++) begin
            next();
            en = '1;
            apply();
            commit();
        end
        chk("rr_beats", BW'(q_src.size()), BW'(80));
        for (int n = 0; n < 80 && n < q_src.size(); n++) begin
            chk("rr_src",    BW'(q_src[n]),  BW'((n / 10) % 7));
            chk("rr_stream", q_data[n],      mk((n / 10) % 7, (n / 10 == 7) ? (n % 10) + 10 : n % 10));
            chk("rr_last",   BW'(q_last[n]), (n % 10 == 9) ? BW'(1) : '0);
            chk("rr_cycle",  BW'(q_cyc[n]),  BW'(2 + n + n / 10));
        end
        next();
        chk("rr_pkt_count", BW'(pkt_count), BW'(8));

        // ---- Backpressure on beat 4 of level 4 ----
        do_reset();
        stall = 0;
        for (int c = 0; c < 60 && q_src.size() < 10; c++) begin
            next();
            en = '0;
            en[4] = (sent[4] < PB);
            if (out_valid && out_stream == mk(4, 4) && stall < 5) begin
                out_ready = 1'b0;
                stall++;
            end else begin
                out_ready = 1'b1;
            end
            apply();
            if (!out_ready) begin
                chk("bp_hold_stream", out_stream,    mk(4, 4));
                chk("bp_hold_src",    BW'(out_src),  BW'(4));
                chk("bp_hold_last",   BW'(out_last), '0);
                chk("bp_in_ready",    BW'(in_ready), '0);
            end
            commit();
        end
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            next();
            en = '0;
            apply();
            commit();
        end
        chk("bp_stalls", BW'(stall), BW'(5));
        chk("bp_beats",  BW'(q_src.size()), BW'(10));
        for (int n = 0; n < 10 && n < q_src.size(); n++) begin
            chk("bp_stream", q_data[n],      mk(4, n));
            chk("bp_src",    BW'(q_src[n]),  BW'(4));
            chk("bp_last",   BW'(q_last[n]), (n == 9) ? BW'(1) : '0);
        end

        // ---- Bubble on granted level 2 while level 5 waits ----
        do_reset();
        bub = 0;
        for (int c = 0; c < 80 && q_src.size() < 11; c++) begin
            next();
            en = '0;
            en[5] = 1'b1;
            en[2] = (sent[2] < PB);
            if (sent[2] == 4 && bub < 3) begin
                en[2] = 1'b0;
                bub++;
            end
            apply();
            if (q_src.size() < 10) chk("bub_rdy5", BW'(in_ready[5]), '0);
            commit();
        end
        chk("bub_count", BW'(bub), BW'(3));
        chk("bub_beats", BW'(q_src.size()), BW'(11));
        if (q_src.size() >= 11) begin
            for (int n = 0; n < 10; n++) begin
                chk("bub_src2",    BW'(q_src[n]), BW'(2));
                chk("bub_stream2", q_data[n],     mk(2, n));
            end
            chk("bub_last2",     BW'(q_last[9]), BW'(1));
            chk("bub_src5",      BW'(q_src[10]), BW'(5));
            chk("bub_gap",       BW'(q_cyc[10] - q_cyc[9]), BW'(2));
        end

        // ---- Reset pulse mid-packet ----
        do_reset();
        found = 1'b0;
        for (int c = 0; c < 40; c++) begin
            next();
            en = '0;
            en[1] = 1'b1;
            apply();
            if (out_valid && out_stream == mk(1, 5)) begin
                found = 1'b1;
                break;
            end
            commit();
        end
        chk("mid_found_beat5", BW'(found), BW'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("mid_rst");
        for (int j = 0; j < LV; j++) sent[j] = 0;
        en = 7'b0000011;
        apply();
        next();
        next();
        rst_n = 1'b1;
        clear_q();
        for (int c = 0; c < 30 && q_src.size() < 1; c++) begin
            next();
            en = 7'b0000011;
            apply();
            commit();
        end
        chk("mid_beats", BW'(q_src.size()), BW'(1));
        if (q_src.size() >= 1) begin
            chk("mid_first_src",    BW'(q_src[0]), '0);
            chk("mid_first_stream", q_data[0],     mk(0, 0));
        end
        chk("mid_pkt_count", BW'(pkt_count), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/window_stream_arbiter.md
Name: window_stream_arbiter

Overview:
- Merges the LEVELS per-pyramid-level serialized window streams, produced by the window serializers in the 140 MHz domain, into one BUS_WIDTH stream.
- Its output feeds the external bus bridge toward the HPS.
- Arbitration is packet-atomic round-robin: once a level is granted, the arbiter stays locked to it for a full window packet of PKT_BEATS beats.
- Each output beat is tagged with its source level and a last-beat flag.

Parameters:
- BUS_WIDTH, 128, width of each stream beat
- LEVELS, 7, number of input streams (pyramid levels)
- PKT_BEATS, 10, beats per window packet (1 metadata header + 9 data beats of a 1152-bit window)
- SRC_W, 3, width of source index; must satisfy 2**SRC_W >= LEVELS
- CNT_W, 16, width of the packet counter

Ports:
- clk  in  1  single clock (clk_140 domain)
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  LEVELS  per-level beat valid
- in_stream  in  BUS_WIDTH*LEVELS  concatenated beats; level j occupies [j*BUS_WIDTH +: BUS_WIDTH]
- in_ready  out  LEVELS  per-level beat accept
- out_valid  out  1  output beat valid
- out_stream  out  BUS_WIDTH  output beat
- out_last  out  1  marks the final beat of a packet
- out_src  out  SRC_W  level index of the current beat
- out_ready  in  1  downstream accept
- pkt_count  out  CNT_W  number of completed packets emitted; wraps modulo 2**CNT_W

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, out_stream=0, out_last=0, out_src=0, in_ready=0, pkt_count=0.
  - FSM=IDLE, beat counter=0, round-robin pointer=LEVELS-1, so level 0 has top priority first.
- Handshakes:
  - A transfer occurs on a cycle where valid&&ready are both high.
  - Output data and tags hold stable while out_valid=1 and out_ready=0.
- State IDLE:
  - in_ready=0.
  - If any in_valid is high, grant the first requesting level searching upward from ptr+1, with wrap-around.
  - The grant is registered and the FSM moves to BURST on the next edge.
  - No beat is accepted in the IDLE cycle.
- State BURST:
  - can_load = !out_valid || out_ready.
  - in_ready[g] = can_load for the granted level g; all other in_ready bits are 0. This is combinational from out_ready.
  - On an accepted beat:
    - out_stream <= in_stream[g], out_src <= g, out_valid <= 1.
    - out_last <= (beat counter == PKT_BEATS-1).
    - Beat counter increments.
  - When the counter reaches PKT_BEATS-1 and that beat is accepted:
    - Counter resets to 0, ptr <= g, FSM returns to IDLE.
  - If no beat is accepted but out_ready=1, out_valid <= 0.
- Grant locking:
  - The grant is held across input bubbles (in_valid[g]=0) indefinitely, with no timeout.
  - Other levels are never granted mid-packet, even if they are valid.
- pkt_count increments by 1 when the beat with out_last=1 transfers on the output (out_valid && out_ready && out_last).
- Latency:
  - Request in cycle 0 from IDLE gives in_ready in cycle 1 and first out_valid in cycle 2.
  - Throughput is 1 beat/cycle within a packet, with 1 idle arbitration cycle between packets.
- Boundary conditions:
  - The output stage is a single register; with sustained out_ready=1 it incurs no bubbles.
  - A level whose in_valid drops while not granted incurs no penalty.
  - If all in_valid are low in IDLE, the FSM stays in IDLE.
  - Reset mid-packet: the partial packet is discarded, all state clears immediately, and after release arbitration restarts at level 0.
  - The PKT_BEATS count is the only packet delimiter; no input last signal is used.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> all outputs 0; after release with no in_valid, out_valid stays 0 for 20 cycles.
- Single level 3 streaming beats 0x..0..0x..9, out_ready=1, request in cycle 0 -> in_ready[3]=1 in cycles 1–10; out_valid in cycles 2–11; out_src=3; out_last only in cycle 11; pkt_count=1.
- All 7 levels valid continuously after reset -> packet order 0,1,2,3,4,5,6,0; each packet has 10 beats and one idle cycle between packets; pkt_count=8 after eight packets.
- Backpressure: out_ready=0 for 5 cycles during beat 4 -> out_stream/out_src/out_last held constant; in_ready[g]=0; 10 beats delivered in order with none lost or duplicated.
- Bubble: level 2 granted, in_valid[2]=0 during beats 4–6, level 5 valid throughout -> grant stays on level 2; level 5 is granted only after level 2's out_last, in the next IDLE cycle.
- Reset pulse at beat 5 of a level-1 packet -> outputs 0 asynchronously; after release, the level-1 and level-0 requests yield level 0 granted first; pkt_count=0.
